// File: rtl/vna_pkt_pkg.sv
// Shared definitions for the VNA measurement packetiser: header defaults,
// header field positions, beat counts and the packetiser state encoding.
package vna_pkt_pkg;

   localparam logic [15:0] MAGIC_DEF   = 16'hA5C3;
   localparam logic [7:0]  VERSION_DEF = 8'h01;

   // Header word layout, LSB position of each field
   localparam int HDR_MAGIC_LSB = 48;
   localparam int HDR_SEQ_LSB   = 32;
   localparam int HDR_DROP_LSB  = 16;
   localparam int HDR_COUNT_LSB = 8;
   localparam int HDR_VER_LSB   = 0;

   // Packet lengths without and with the trailing checksum beat
   localparam logic [3:0] BEATS_PLAIN = 4'd7;
   localparam logic [3:0] BEATS_CSUM  = 4'd8;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   // Assemble the header beat from its fields
   function automatic logic [63:0] make_header(
      input logic [15:0] magic,
      input logic [15:0] seq,
      input logic [15:0] drop,
      input logic [7:0]  count,
      input logic [7:0]  version
   );
      logic [63:0] hdr;
      hdr = 64'd0;
      hdr[HDR_MAGIC_LSB +: 16] = magic;
      hdr[HDR_SEQ_LSB   +: 16] = seq;
      hdr[HDR_DROP_LSB  +: 16] = drop;
      hdr[HDR_COUNT_LSB +: 8]  = count;
      hdr[HDR_VER_LSB   +: 8]  = version;
      return hdr;
   endfunction

endpackage

// File: rtl/vna_pkt_checksum.sv
// Running XOR accumulator over the beats of one packet. Cleared when a new
// packet is captured, folds in the presented beat on each handshake.
module vna_pkt_checksum (
   input  logic        aclk,
   input  logic        rst,
   input  logic        clear,
   input  logic        fold,
   input  logic [63:0] data,
   output logic [63:0] acc
);

   logic [63:0] acc_r;

   // Accumulator register: clear has priority over folding
   always_ff @(posedge aclk or negedge rst) begin
      if (!rst) begin
         acc_r <= 64'd0;
      end else if (clear) begin
         acc_r <= 64'd0;
      end else if (fold) begin
         acc_r <= acc_r ^ data;
      end else begin
         acc_r <= acc_r;
      end
   end

   assign acc = acc_r;

endmodule

// File: rtl/vna_packetiser.sv
// Snapshots one measurement set (four 64-bit values, four 32-bit counts) on
// a trigger and streams it as a fixed-length AXI4-Stream packet.
// Optional feature: define VNA_PACKETISER_CHECKSUM_EN to append an XOR
// checksum beat (8 beats per packet instead of 7).
module vna_packetiser
   import vna_pkt_pkg::*;
#(
   parameter logic [15:0] MAGIC   = MAGIC_DEF,
   parameter logic [7:0]  VERSION = VERSION_DEF
) (
   input  logic        aclk,
   input  logic        rst,
   input  logic [63:0] val_1,
   input  logic [63:0] val_2,
   input  logic [63:0] val_3,
   input  logic [63:0] val_4,
   input  logic [31:0] cnt_1,
   input  logic [31:0] cnt_2,
   input  logic [31:0] cnt_3,
   input  logic [31:0] cnt_4,
   input  logic        trigger,
   output logic [63:0] m_axis_tdata,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic        m_axis_tlast,
   output logic [7:0]  m_axis_tkeep,
   output logic        busy,
   output logic [15:0] drop_cnt,
   output logic [15:0] seq
);

`ifdef VNA_PACKETISER_CHECKSUM_EN
   localparam logic [3:0] NUM_BEATS = BEATS_CSUM;
`else
   localparam logic [3:0] NUM_BEATS = BEATS_PLAIN;
`endif
   localparam logic [3:0] LAST_IDX4 = NUM_BEATS - 4'd1;
   localparam logic [2:0] LAST_IDX  = LAST_IDX4[2:0];

   state_t      state_r;
   state_t      state_nxt_s;
   logic [2:0]  idx_r;
   logic [2:0]  idx_inc_s;
   logic [63:0] val1_r, val2_r, val3_r, val4_r;
   logic [31:0] cnt1_r, cnt2_r, cnt3_r, cnt4_r;
   logic [15:0] seq_r;
   logic [15:0] drop_r;
   logic [63:0] tdata_r;
   logic        tvalid_r;
   logic        tlast_r;
   logic [7:0]  tkeep_r;
   logic        busy_r;

   logic        handshake_s;
   logic        final_hs_s;
   logic        capture_s;
   logic        drop_s;
   logic [63:0] hdr_s;
   logic [63:0] next_word_s;

`ifdef VNA_PACKETISER_CHECKSUM_EN
   logic [63:0] csum_s;

   vna_pkt_checksum u_checksum (
      .aclk  (aclk),
      .rst   (rst),
      .clear (capture_s),
      .fold  (handshake_s),
      .data  (tdata_r),
      .acc   (csum_s)
   );
`endif

   assign handshake_s = tvalid_r & m_axis_tready;
   assign final_hs_s  = handshake_s & tlast_r;
   assign idx_inc_s   = idx_r + 3'd1;
   assign hdr_s       = make_header(MAGIC, seq_r + 16'd1, drop_r, {4'd0, NUM_BEATS}, VERSION);

   // Next-state decode plus capture/drop qualification of the trigger
   always_comb begin
      state_nxt_s = state_r;
      capture_s   = 1'b0;
      drop_s      = 1'b0;
      case (state_r)
         IDLE: begin
            if (trigger) begin
               capture_s   = 1'b1;
               state_nxt_s = SEND;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         SEND: begin
            if (trigger && final_hs_s) begin
               capture_s   = 1'b1;
               state_nxt_s = SEND;
            end else if (trigger) begin
               drop_s      = 1'b1;
               state_nxt_s = SEND;
            end else if (final_hs_s) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = SEND;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Select the beat that follows the one currently presented
   always_comb begin
      next_word_s = 64'd0;
      case (idx_inc_s)
         3'd1:    next_word_s = val1_r;
         3'd2:    next_word_s = val2_r;
         3'd3:    next_word_s = val3_r;
         3'd4:    next_word_s = val4_r;
         3'd5:    next_word_s = {cnt2_r, cnt1_r};
         3'd6:    next_word_s = {cnt4_r, cnt3_r};
`ifdef VNA_PACKETISER_CHECKSUM_EN
         // accumulator holds w0..w5; w6 is still on the bus
         3'd7:    next_word_s = csum_s ^ tdata_r;
`endif
         default: next_word_s = 64'd0;
      endcase
   end

   // State register
   always_ff @(posedge aclk or negedge rst) begin
      if (!rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Snapshot, sequence/drop counters and registered stream outputs
   always_ff @(posedge aclk or negedge rst) begin
      if (!rst) begin
         idx_r    <= 3'd0;
         val1_r   <= 64'd0;
         val2_r   <= 64'd0;
         val3_r   <= 64'd0;
         val4_r   <= 64'd0;
         cnt1_r   <= 32'd0;
         cnt2_r   <= 32'd0;
         cnt3_r   <= 32'd0;
         cnt4_r   <= 32'd0;
         seq_r    <= 16'd0;
         drop_r   <= 16'd0;
         tdata_r  <= 64'd0;
         tvalid_r <= 1'b0;
         tlast_r  <= 1'b0;
         tkeep_r  <= 8'hFF;
         busy_r   <= 1'b0;
      end else begin
         tkeep_r <= 8'hFF;
         if (capture_s) begin
            val1_r   <= val_1;
            val2_r   <= val_2;
            val3_r   <= val_3;
            val4_r   <= val_4;
            cnt1_r   <= cnt_1;
            cnt2_r   <= cnt_2;
            cnt3_r   <= cnt_3;
            cnt4_r   <= cnt_4;
            seq_r    <= seq_r + 16'd1;
            idx_r    <= 3'd0;
            tdata_r  <= hdr_s;
            tvalid_r <= 1'b1;
            tlast_r  <= 1'b0;
            busy_r   <= 1'b1;
         end else if (final_hs_s) begin
            idx_r    <= 3'd0;
            tdata_r  <= 64'd0;
            tvalid_r <= 1'b0;
            tlast_r  <= 1'b0;
            busy_r   <= 1'b0;
         end else if (handshake_s) begin
            idx_r   <= idx_inc_s;
            tdata_r <= next_word_s;
            tlast_r <= (idx_inc_s == LAST_IDX);
         end else begin
            idx_r <= idx_r;
         end
         if (drop_s && (drop_r != 16'hFFFF)) begin
            drop_r <= drop_r + 16'd1;
         end else begin
            drop_r <= drop_r;
         end
      end
   end

   assign m_axis_tdata  = tdata_r;
   assign m_axis_tvalid = tvalid_r;
   assign m_axis_tlast  = tlast_r;
   assign m_axis_tkeep  = tkeep_r;
   assign busy          = busy_r;
   assign drop_cnt      = drop_r;
   assign seq           = seq_r;

endmodule
